// File: rtl/bcd_array_sorter_if.sv
// Digit load / sort control / result bus of the BCD array sorter.
// Latency: none, this is only a bundle of wires.
// Backpressure: in_ready qualifies in_valid; start/clear are single-cycle pulses.
interface bcd_array_sorter_if;
  logic       in_valid;
  logic [3:0] in_digit;
  logic       in_ready;
  logic       start;
  logic       clear;
  logic       busy;
  logic       done;
  logic       bad_digit;
  logic [4:0] count;
  logic [3:0] arrayFirst;
  logic [3:0] arrayLast;

  // Sorter side
  modport slave (
    input  in_valid, in_digit, start, clear,
    output in_ready, busy, done, bad_digit, count, arrayFirst, arrayLast
  );

  // Producer / controller side
  modport master (
    output in_valid, in_digit, start, clear,
    input  in_ready, busy, done, bad_digit, count, arrayFirst, arrayLast
  );
endinterface

// File: rtl/bcd_array_sorter.sv
// Loads BCD digits into a DEPTH-entry array, bubble-sorts it, shows min/max (4'hF when no result).
// Latency: one compare per cycle; done N cycles after start for sorted input, N(N-1)/2+1 worst case.
// Backpressure: in_ready low when the array is full or while sorting/holding a result.
module bcd_array_sorter #(
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  bcd_array_sorter_if.slave  bus
);

  typedef enum logic [1:0] {S_LOAD, S_SORT, S_DONE} state_t;

  localparam logic [4:0] DEPTH_C = 5'(DEPTH);
  localparam logic [3:0] BLANK   = 4'hF;

  state_t     state_q;
  logic [4:0] count_q;
  logic [4:0] lim_q;
  logic [3:0] j_q;
  logic       swapped_q;
  logic       in_ready_q;
  logic       busy_q;
  logic       done_q;
  logic       bad_q;
  logic [3:0] first_q;
  logic [3:0] last_q;

  // Sized to the 4-bit index; only the first DEPTH entries are ever written.
  logic [3:0] mem_q [16];
  logic [3:0] mem_d [16];

  logic       acc;
  logic       acc_ok;
  logic [3:0] jp1;
  logic [3:0] cmp_a;
  logic [3:0] cmp_b;
  logic       swap;
  logic [4:0] count_after;
  logic [4:0] last_idx;
  logic [3:0] first_nx;
  logic [3:0] last_nx;
  logic       pass_end;
  logic       sort_fin;

  // Handshake and compare datapath; clear wins over a same-cycle digit.
  always_comb begin
    acc         = (state_q == S_LOAD) && bus.in_valid && (count_q < DEPTH_C) && !bus.clear;
    acc_ok      = acc && (bus.in_digit <= 4'd9);
    jp1         = j_q + 4'd1;
    cmp_a       = mem_q[j_q];
    cmp_b       = mem_q[jp1];
    swap        = (state_q == S_SORT) && (cmp_a > cmp_b);
    count_after = count_q + {4'd0, acc_ok};
    pass_end    = ({1'b0, j_q} == (lim_q - 5'd2));
    sort_fin    = pass_end && (!(swapped_q || swap) || (lim_q == 5'd2));
  end

  // Next array contents: a digit write in LOAD or a compare-swap in SORT.
  always_comb begin
    mem_d = mem_q;
    if (acc_ok) begin
      mem_d[count_q[3:0]] = bus.in_digit;
    end
    if (swap) begin
      mem_d[j_q] = cmp_b;
      mem_d[jp1] = cmp_a;
    end
    last_idx = count_after - 5'd1;
    first_nx = mem_d[0];
    last_nx  = mem_d[last_idx[3:0]];
  end

  // Array storage, intentionally not reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Control FSM with registered status and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_LOAD;
      count_q    <= 5'd0;
      lim_q      <= 5'd0;
      j_q        <= 4'd0;
      swapped_q  <= 1'b0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bad_q      <= 1'b0;
      first_q    <= BLANK;
      last_q     <= BLANK;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (bus.clear) begin
            count_q    <= 5'd0;
            bad_q      <= 1'b0;
            in_ready_q <= 1'b1;
          end else begin
            count_q <= count_after;
            if (acc && !acc_ok) begin
              bad_q <= 1'b1;
            end
            if (bus.start && (count_after == 5'd1)) begin
              state_q    <= S_DONE;
              done_q     <= 1'b1;
              in_ready_q <= 1'b0;
              first_q    <= first_nx;
              last_q     <= last_nx;
            end else if (bus.start && (count_after >= 5'd2)) begin
              state_q    <= S_SORT;
              busy_q     <= 1'b1;
              in_ready_q <= 1'b0;
              lim_q      <= count_after;
              j_q        <= 4'd0;
              swapped_q  <= 1'b0;
            end else begin
              in_ready_q <= (count_after < DEPTH_C);
            end
          end
        end
        S_SORT: begin
          if (sort_fin) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            first_q <= first_nx;
            last_q  <= last_nx;
          end else if (pass_end) begin
            lim_q     <= lim_q - 5'd1;
            j_q       <= 4'd0;
            swapped_q <= 1'b0;
          end else begin
            j_q       <= jp1;
            swapped_q <= swapped_q | swap;
          end
        end
        S_DONE: begin
          if (bus.clear) begin
            state_q    <= S_LOAD;
            done_q     <= 1'b0;
            count_q    <= 5'd0;
            bad_q      <= 1'b0;
            in_ready_q <= 1'b1;
            first_q    <= BLANK;
            last_q     <= BLANK;
          end
        end
        default: begin
          state_q <= S_LOAD;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.bad_digit  = bad_q;
  assign bus.count      = count_q;
  assign bus.arrayFirst = first_q;
  assign bus.arrayLast  = last_q;

endmodule

// File: tb/tb_bcd_array_sorter.sv
// Bench for bcd_array_sorter: directed steps plus random loads against a queue-based model.
// Latency: checks done timing and number of busy (compare) cycles per sort.
// Backpressure: model tracks in_ready/full and dropped bad digits.
module tb_bcd_array_sorter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  logic [3:0] mq[$];
  bit         mbad;

  bcd_array_sorter_if bus();

  bcd_array_sorter #(.DEPTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_offer(input logic [3:0] d);
    if (mq.size() < 8) begin
      if (d <= 4'd9) mq.push_back(d);
      else mbad = 1'b1;
    end
  endtask

  task automatic push(input logic [3:0] d);
    bus.in_valid = 1'b1;
    bus.in_digit = d;
    tick();
    bus.in_valid = 1'b0;
    model_offer(d);
    check("count", bus.count, mq.size());
    check("in_ready", bus.in_ready, (mq.size() < 8) ? 1 : 0);
    check("bad_digit", bus.bad_digit, mbad);
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    mq.delete();
    mbad = 1'b0;
    check("clr_done", bus.done, 0);
    check("clr_first", bus.arrayFirst, 4'hF);
    check("clr_last", bus.arrayLast, 4'hF);
    check("clr_ready", bus.in_ready, 1);
    check("clr_bad", bus.bad_digit, 0);
    check("clr_count", bus.count, 0);
  endtask

  // Start a sort (optionally with a same-cycle digit) and check result and timing.
  task automatic run_sort(input bit with_d, input logic [3:0] d);
    logic [3:0] a[$];
    logic [3:0] s[$];
    logic [3:0] t;
    int n, comps, i, busy_n, lim;
    bit sw, fin;
    if (with_d) begin
      bus.in_valid = 1'b1;
      bus.in_digit = d;
      model_offer(d);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    n = mq.size();
    a = mq;
    comps = 0;
    if (n >= 2) begin
      lim = n;
      fin = 1'b0;
      while (!fin) begin
        sw = 1'b0;
        for (int j = 0; j < lim - 1; j++) begin
          comps++;
          if (a[j] > a[j+1]) begin
            t = a[j]; a[j] = a[j+1]; a[j+1] = t; sw = 1'b1;
          end
        end
        fin = !sw || (lim == 2);
        lim--;
      end
    end
    i = 1;
    busy_n = 0;
    while (bus.done !== 1'b1 && i < 400) begin
      if (bus.busy === 1'b1) busy_n++;
      tick();
      i++;
    end
    check("done_seen", bus.done, 1);
    check("done_latency", i, comps + 1);
    check("compare_cycles", busy_n, comps);
    s = mq;
    s.sort();
    check("first", bus.arrayFirst, s[0]);
    check("last", bus.arrayLast, s[n-1]);
    check("done_count", bus.count, n);
    check("done_busy", bus.busy, 0);
    check("done_ready", bus.in_ready, 0);
    for (int k = 0; k < n; k++) check("mem_order", dut.mem_q[k], s[k]);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    mbad = 1'b0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_digit = 4'd0;
    bus.start = 1'b0;
    bus.clear = 1'b0;
    tick();
    tick();
    check("rst_first", bus.arrayFirst, 4'hF);
    check("rst_last", bus.arrayLast, 4'hF);
    check("rst_count", bus.count, 0);
    check("rst_ready", bus.in_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_bad", bus.bad_digit, 0);
    rst_n = 1'b1;
    tick();

    // start with nothing loaded is ignored
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("empty_start_busy", bus.busy, 0);
    check("empty_start_done", bus.done, 0);

    // 5,3,9,1
    push(5); push(3); push(9); push(1);
    run_sort(1'b0, 4'd0);
    // start while done is ignored
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("done_start_ign", bus.done, 1);
    check("done_start_busy", bus.busy, 0);
    do_clear();

    // Overfill with 9..1: last digit refused; worst-case sort
    for (int v = 9; v >= 1; v--) push(4'(v));
    run_sort(1'b0, 4'd0);
    do_clear();

    // Already sorted 0..7
    for (int v = 0; v < 8; v++) push(4'(v));
    run_sort(1'b0, 4'd0);
    do_clear();

    // Bad digit dropped
    push(4); push(12); push(6);
    check("bad_sticky", bus.bad_digit, 1);
    run_sort(1'b0, 4'd0);
    check("bad_kept_done", bus.bad_digit, 1);
    do_clear();

    // Single digit with same-cycle start
    run_sort(1'b1, 4'd7);
    do_clear();

    // clear in LOAD drops loaded digits and bad flag
    push(3); push(15);
    do_clear();

    // Reset mid-sort
    for (int v = 6; v >= 1; v--) push(4'(v));
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check("pre_rst_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check("arst_first", bus.arrayFirst, 4'hF);
    check("arst_last", bus.arrayLast, 4'hF);
    check("arst_count", bus.count, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_ready", bus.in_ready, 1);
    tick();
    rst_n = 1'b1;
    mq.delete();
    mbad = 1'b0;
    tick();
    push(2); push(1);
    run_sort(1'b0, 4'd0);
    do_clear();

    // Random loads, including bad digits and overfill
    for (int r = 0; r < 8; r++) begin
      int len;
      len = $urandom_range(1, 11);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 5) == 0) push(4'($urandom_range(10, 15)));
        else push(4'($urandom_range(0, 9)));
      end
      if (mq.size() == 0) push(4'd5);
      if ($urandom_range(0, 1) == 1 && mq.size() < 8) run_sort(1'b1, 4'($urandom_range(0, 9)));
      else run_sort(1'b0, 4'd0);
      check("rand_bad", bus.bad_digit, mbad);
      do_clear();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bcd_array_sorter.md
# bcd_array_sorter

Collects a stream of BCD digits into a small on-chip array, bubble-sorts it in place, and presents the smallest (first) and largest (last) entries as 4-bit BCD codes. Sits directly upstream of the dual BCD-to-7-segment display stage and drives its first/last digit inputs. While no valid result exists it drives 4'hF on both outputs, which the display stage shows as a blank digit.

## Interface
- DEPTH, 8: array capacity in digits; legal range 2..16.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_digit carries a digit this cycle.
- in_digit  in  4  BCD digit to load.
- in_ready  out  1  block accepts a digit this cycle.
- start  in  1  single-cycle pulse: begin sorting the loaded digits.
- clear  in  1  single-cycle pulse: discard the result and return to loading.
- busy  out  1  sort in progress.
- done  out  1  result valid on arrayFirst/arrayLast.
- bad_digit  out  1  sticky: a digit 10..15 was offered and dropped.
- count  out  5  number of digits stored (0..DEPTH).
- arrayFirst  out  4  minimum stored digit when done, else 4'hF.
- arrayLast  out  4  maximum stored digit when done, else 4'hF.

## Operation
- Three-state FSM: LOAD, SORT, DONE. Storage: DEPTH x 4-bit registers mem[0..DEPTH-1]; contents are not reset.
- LOAD: in_ready = (count < DEPTH). A digit is accepted when in_valid && in_ready.
  - Digit 0..9: written to mem[count]; count increments.
  - Digit 10..15: dropped, count unchanged, bad_digit set.
- start in LOAD:
  - count == 0 after this cycle's accept: ignored.
  - count == 1: go directly to DONE.
  - Otherwise: go to SORT.
- Same-cycle in_valid and start in LOAD: the digit is accepted first and is included in the sort.
- SORT: compare-swap bubble sort, ascending, one compare per cycle.
  - Pass limit L starts at count; pointer j runs 0..L-2.
  - Each cycle compares mem[j] and mem[j+1] and swaps them if mem[j] > mem[j+1].
  - At j = L-2: if no swap occurred in this pass, or L == 2, go to DONE. Otherwise set L = L-1, j = 0, and clear the pass swap flag.
- DONE: done = 1, arrayFirst = mem[0], arrayLast = mem[count-1], both registered.
  - clear: go to LOAD; count = 0; arrayFirst/arrayLast = 4'hF; bad_digit cleared.
- clear in LOAD also zeroes count and bad_digit. clear has priority over a same-cycle in_valid or start.
- start during SORT or DONE is ignored. clear during SORT is ignored; the sort completes.
- in_ready = 0 in SORT and DONE. busy = 1 only in SORT.
- Equal digits are never swapped, so the sort is stable.

## Timing
- Reset (async assert, sync release) sets:
  - state LOAD, count 0, in_ready 1, busy 0, done 0, bad_digit 0, arrayFirst = arrayLast = 4'hF.
- Reset during SORT or DONE abandons the operation immediately.
- An accepted digit is visible in count on the next cycle.
- start sampled at edge t:
  - busy = 1 from t+1.
  - Each compare takes one cycle.
  - done = 1 and arrayFirst/arrayLast are valid in the cycle after the final compare.
- Sorted input of N digits: done at t+N (N-1 compares). Worst case: N(N-1)/2 compares.
- count == 1: done = 1 at t+1.
- clear sampled at edge t: done = 0, outputs 4'hF, in_ready = 1 from t+1.

## Test plan
- Load 5,3,9,1; pulse start -> busy set; done rises; arrayFirst = 4'd1, arrayLast = 4'd9, count = 4; internal order is 1,3,5,9.
- DEPTH = 8: offer 9,8,7,6,5,4,3,2,1 -> in_ready drops after the 8th digit and the 9th is not taken. Sort gives first = 2, last = 9, after 28 compare cycles.
- Load 0..7 in order; start at edge t -> done at t+8; first = 0, last = 7.
- Offer 4, 12, 6 -> count = 2, bad_digit = 1. After the sort: first = 4, last = 6. Pulse clear -> bad_digit = 0, outputs 4'hF.
- Single digit 7 with in_valid and start in the same cycle -> done at t+1; first = last = 7.
- Assert rst_n low mid-sort -> outputs return to 4'hF, count = 0, state LOAD. A reload of 2,1 then sorts to first = 1, last = 2.
